keysw_io_responder: RTL

Memory-mapped responder for the processor's KEY and SW I/O addresses, at the device end of the processor's MAR/WrMem/DrMem I/O protocol. It synchronizes the raw KEY and SW pins and debounces SW. Each device gets a data register and a control/status register with sticky Ready/Overrun bits and interrupt enable. Read data returns combinationally for the processor's single-cycle memory-drive state, with clear-on-read side effects applied at the clock edge.

---
 rtl/keysw_io_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/keysw_io_responder.sv
// rtl/keysw_io_responder.sv - KEY/SW memory-mapped I/O responder
// Synchronizes KEY, synchronizes and debounces SW, exposes data + ctrl/status registers.
module keysw_io_responder #(
   parameter int DBITS = 32,
   parameter int KEYBITS = 4,
   parameter int SWBITS = 10,
   parameter logic [DBITS-1:0] ADDRKEY = 32'hFFFFF080,
   parameter logic [DBITS-1:0] ADDRSW = 32'hFFFFF090,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DBITS-1:0]   addr,
   input  logic [DBITS-1:0]   wdata,
   input  logic               we,
   input  logic               re,
   output logic [DBITS-1:0]   rdata,
   output logic               rsel,
   input  logic [KEYBITS-1:0] KEY,
   input  logic [SWBITS-1:0]  SW,
   output logic               irq
);

   localparam logic [DBITS-1:0] KDATA_A = ADDRKEY;
   localparam logic [DBITS-1:0] KCTRL_A = ADDRKEY + DBITS'(4);
   localparam logic [DBITS-1:0] SDATA_A = ADDRSW;
   localparam logic [DBITS-1:0] SCTRL_A = ADDRSW + DBITS'(4);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam int RDY_BIT = 0;
   localparam int OVR_BIT = 2;
   localparam int IE_BIT = 8;

   logic [KEYBITS-1:0] key_s1, key_s2, kdata;
   logic [SWBITS-1:0]  sw_s1, sw_s2, sw_cand, sdata;
   logic [CW-1:0]      sw_cnt;
   logic               krdy, kovr, kie, srdy, sovr, sie;

   logic hit_kd, hit_kc, hit_sd, hit_sc;
   logic k_rd, k_cw, s_rd, s_cw, k_upd, s_upd;
   logic unused_wdata;

   assign hit_kd = (addr == KDATA_A);
   assign hit_kc = (addr == KCTRL_A);
   assign hit_sd = (addr == SDATA_A);
   assign hit_sc = (addr == SCTRL_A);

   assign k_rd = re & hit_kd;
   assign s_rd = re & hit_sd;
   assign k_cw = we & hit_kc;
   assign s_cw = we & hit_sc;

   assign k_upd = (key_s2 != kdata);
   // Accept only once the candidate has survived the full count and actually differs.
   assign s_upd = (sw_s2 == sw_cand) && (sw_cnt == CNT_LAST) && (sw_cand != sdata);

   assign unused_wdata = ^{wdata[DBITS-1:IE_BIT+1], wdata[IE_BIT-1:OVR_BIT+1], wdata[OVR_BIT-1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_s1  <= '0;
         key_s2  <= '0;
         kdata   <= '0;
         sw_s1   <= '0;
         sw_s2   <= '0;
         sw_cand <= '0;
         sw_cnt  <= '0;
         sdata   <= '0;
         krdy    <= 1'b0;
         kovr    <= 1'b0;
         kie     <= 1'b0;
         srdy    <= 1'b0;
         sovr    <= 1'b0;
         sie     <= 1'b0;
      end else begin
         key_s1 <= ~KEY;
         key_s2 <= key_s1;
         if (k_upd)
            kdata <= key_s2;

         sw_s1 <= SW;
         sw_s2 <= sw_s1;
         if (sw_s2 != sw_cand) begin
            sw_cand <= sw_s2;
            sw_cnt  <= '0;
         end else if (sw_cnt != CNT_LAST) begin
            sw_cnt <= sw_cnt + 1'b1;
         end else if (sw_cand != sdata) begin
            sdata <= sw_cand;
         end

         // A read in the same cycle as an update consumes the old value: no overrun.
         krdy <= k_upd | (krdy & ~k_rd);
         if (k_upd & krdy & ~k_rd)
            kovr <= 1'b1;
         else if (k_cw & ~wdata[OVR_BIT])
            kovr <= 1'b0;
         if (k_cw)
            kie <= wdata[IE_BIT];

         srdy <= s_upd | (srdy & ~s_rd);
         if (s_upd & srdy & ~s_rd)
            sovr <= 1'b1;
         else if (s_cw & ~wdata[OVR_BIT])
            sovr <= 1'b0;
         if (s_cw)
            sie <= wdata[IE_BIT];
      end
   end

   assign rsel = re & (hit_kd | hit_kc | hit_sd | hit_sc);
   assign irq  = (krdy & kie) | (srdy & sie);

   always_comb begin
      rdata = '0;
      if (rsel) begin
         if (hit_kd) begin
            rdata = DBITS'(kdata);
         end else if (hit_sd) begin
            rdata = DBITS'(sdata);
         end else if (hit_kc) begin
            rdata[RDY_BIT] = krdy;
            rdata[OVR_BIT] = kovr;
            rdata[IE_BIT]  = kie;
         end else begin
            rdata[RDY_BIT] = srdy;
            rdata[OVR_BIT] = sovr;
            rdata[IE_BIT]  = sie;
         end
      end
   end

endmodule
